// File: rtl/conv_result_pkg.sv
// conv_result_pkg: shared constants and types for the conv_pool result collector.
// Contents:
//   CH_W / NUM_CH - channel index width and number of kernel channels
//   PACK / LANE_W / WORD_W - bytes per word, byte width, packed word width
//   WADDR_W       - word-address width (byte address width minus the 2 lane bits)
//   ch_idx_t      - channel index type
//   word_entry_t  - one buffered word: word address plus packed data
package conv_result_pkg;
    localparam int CH_W        = 2;
    localparam int NUM_CH      = 3;
    localparam int PACK        = 4;
    localparam int LANE_W      = 8;
    localparam int WORD_W      = 32;
    // The FIFO entry layout is fixed here, so the byte address width of the
    // collector is tied to this value. Change it here to retarget.
    localparam int DFLT_ADDR_W = 16;
    localparam int WADDR_W     = DFLT_ADDR_W - 2;

    typedef logic [CH_W-1:0] ch_idx_t;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [WORD_W-1:0]  data;
    } word_entry_t;
endpackage

// File: rtl/conv_result_collector_packer.sv
// result_packer: one conv_pool output channel.
// Packs incoming bytes into 32-bit words by address lane, checks that byte
// addresses arrive sequentially, counts received bytes (saturating) and
// buffers completed words in a small first-word-fall-through FIFO.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   we, addr, y        byte write from conv_pool
//   pop                remove the FIFO head (only issued when !empty)
//   head, empty        FIFO head entry and empty flag
//   cnt_full           byte counter has reached TOTAL_BLKS
//   ovf_pulse          a completed word was dropped this cycle
//   seq_err_pulse      this cycle's write address was not the expected one
module result_packer
    import conv_result_pkg::*;
#(
    parameter int ADDR_W     = DFLT_ADDR_W,
    parameter int FIFO_DEPTH = 16,
    parameter int TOTAL_BLKS = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LANE_W-1:0] y,
    input  logic              pop,
    output word_entry_t       head,
    output logic              empty,
    output logic              cnt_full,
    output logic              ovf_pulse,
    output logic              seq_err_pulse
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TOTAL_BLKS + 1);

    logic [WORD_W-1:0] part_reg;
    logic [WORD_W-1:0] word_next;
    logic [ADDR_W-1:0] exp_addr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    word_entry_t       mem [FIFO_DEPTH];
    word_entry_t       push_entry;
    logic              push;
    logic              push_ok;
    logic              full;

    // Partial word with the incoming byte merged into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            assign word_next[gi*LANE_W +: LANE_W] =
                (addr[1:0] == 2'(gi)) ? y : part_reg[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // A write to the top lane closes the word, whatever lanes came before.
    assign push          = we && (addr[1:0] == 2'(PACK - 1));
    assign empty         = (wr_ptr_reg == rd_ptr_reg);
    assign full          = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                           (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    // A full FIFO still takes the word if its head leaves in the same cycle.
    assign push_ok       = push && (!full || pop);
    assign ovf_pulse     = push && full && !pop;
    assign seq_err_pulse = we && (addr != exp_addr_reg);
    assign cnt_full      = (cnt_reg == CNT_W'(TOTAL_BLKS));

    always_comb begin
        push_entry       = '0;
        push_entry.waddr = addr[ADDR_W-1:2];
        push_entry.data  = word_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_reg     <= '0;
            exp_addr_reg <= '0;
            cnt_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            if (we) begin
                exp_addr_reg <= addr + 1'b1;
                part_reg     <= push ? '0 : word_next;
                if (!cnt_full) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    // The head is read combinationally so a word is offered the cycle after
    // it completes.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_entry;
        end
    end

    assign head = mem[rd_ptr_reg[PTR_W-1:0]];
endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: receiving end of the conv_pool byte write streams.
// Three per-channel packers build 32-bit words; a round-robin arbiter drains
// them through one valid/ready stream. Sticky flags report dropped words,
// address sequence errors and completion.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   we_k, addr_k, y_k (k=0..2)  conv_pool byte writes
//   m_valid, m_ready            output handshake
//   m_ch, m_addr, m_data        channel, word address, packed word
//   ovf, seq_err, done          sticky status flags
module conv_result_collector
    import conv_result_pkg::*;
#(
    parameter int ADDR_W     = DFLT_ADDR_W,
    parameter int FIFO_DEPTH = 16,
    parameter int TOTAL_BLKS = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_0,
    input  logic              we_1,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [LANE_W-1:0] y_0,
    input  logic [LANE_W-1:0] y_1,
    input  logic [LANE_W-1:0] y_2,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [ADDR_W-3:0] m_addr,
    output logic [WORD_W-1:0] m_data,
    output logic              ovf,
    output logic              seq_err,
    output logic              done
);
    logic [NUM_CH-1:0] we_v;
    logic [NUM_CH-1:0] empty_v;
    logic [NUM_CH-1:0] pop_v;
    logic [NUM_CH-1:0] cnt_full_v;
    logic [NUM_CH-1:0] ovf_p;
    logic [NUM_CH-1:0] seq_p;
    logic [ADDR_W-1:0] addr_v [NUM_CH];
    logic [LANE_W-1:0] y_v    [NUM_CH];
    word_entry_t       head_v [NUM_CH];

    ch_idx_t           ptr_reg;
    ch_idx_t           gnt_reg;
    logic              lock_reg;
    ch_idx_t           rr_pick;
    ch_idx_t           grant;
    logic              any_valid;
    logic              handshake;
    ch_idx_t           last_ch_reg;
    logic [ADDR_W-3:0] last_addr_reg;
    logic [WORD_W-1:0] last_data_reg;
    logic              ovf_reg;
    logic              seq_err_reg;
    logic              done_reg;

    assign we_v      = {we_2, we_1, we_0};
    assign addr_v[0] = addr_0;
    assign addr_v[1] = addr_1;
    assign addr_v[2] = addr_2;
    assign y_v[0]    = y_0;
    assign y_v[1]    = y_1;
    assign y_v[2]    = y_2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            result_packer #(
                .ADDR_W     (ADDR_W),
                .FIFO_DEPTH (FIFO_DEPTH),
                .TOTAL_BLKS (TOTAL_BLKS)
            ) u_packer (
                .clk           (clk),
                .rst_n         (rst_n),
                .we            (we_v[gi]),
                .addr          (addr_v[gi]),
                .y             (y_v[gi]),
                .pop           (pop_v[gi]),
                .head          (head_v[gi]),
                .empty         (empty_v[gi]),
                .cnt_full      (cnt_full_v[gi]),
                .ovf_pulse     (ovf_p[gi]),
                .seq_err_pulse (seq_p[gi])
            );
            assign pop_v[gi] = handshake && (grant == ch_idx_t'(gi));
        end
    endgenerate

    // First non-empty channel searching upward (mod 3) from the pointer.
    always_comb begin
        int      sum;
        ch_idx_t cand;
        logic    found;
        rr_pick = ptr_reg;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = int'(ptr_reg) + i;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            cand = ch_idx_t'(sum);
            if (!found && !empty_v[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    // A stalled beat keeps its channel even if a higher-priority FIFO fills.
    assign grant     = lock_reg ? gnt_reg : rr_pick;
    assign any_valid = ~&empty_v;
    assign handshake = any_valid && m_ready;

    assign m_valid = any_valid;
    assign m_ch    = any_valid ? grant               : last_ch_reg;
    assign m_addr  = any_valid ? head_v[grant].waddr : last_addr_reg;
    assign m_data  = any_valid ? head_v[grant].data  : last_data_reg;
    assign ovf     = ovf_reg;
    assign seq_err = seq_err_reg;
    assign done    = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            lock_reg      <= 1'b0;
            last_ch_reg   <= '0;
            last_addr_reg <= '0;
            last_data_reg <= '0;
            ovf_reg       <= 1'b0;
            seq_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            lock_reg <= any_valid && !m_ready;
            gnt_reg  <= grant;
            if (handshake) begin
                ptr_reg <= (grant == ch_idx_t'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            // Keep the last offered beat so the outputs hold once idle.
            if (any_valid) begin
                last_ch_reg   <= grant;
                last_addr_reg <= head_v[grant].waddr;
                last_data_reg <= head_v[grant].data;
            end
            ovf_reg     <= ovf_reg | (|ovf_p);
            seq_err_reg <= seq_err_reg | (|seq_p);
            // Empty FIFOs imply no beat is pending.
            done_reg    <= done_reg | (&cnt_full_v && &empty_v);
        end
    end
endmodule

// File: tb/tb_conv_result_collector.sv
// Testbench for conv_result_collector. A queue-based reference model tracks
// per-channel words, drops, address errors and completion; each test task
// drives stimulus and compares the DUT against the model or fixed values.
module tb_conv_result_collector;
    localparam int TB_TOTAL = 16;
    localparam int TB_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we   [3];
    logic [15:0] addr [3];
    logic [7:0]  y    [3];
    logic        m_ready;
    logic        m_valid;
    logic [1:0]  m_ch;
    logic [13:0] m_addr;
    logic [31:0] m_data;
    logic        ovf;
    logic        seq_err;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [45:0] mq [3][$];
    logic [7:0]  mpart [3][4];
    logic [15:0] mexp [3];
    int          mcnt [3];
    int          mptr;
    int          mlock;
    bit          movf, mseq, mdone;
    bit          exp_valid;
    int          exp_ch;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    conv_result_collector #(
        .ADDR_W     (16),
        .FIFO_DEPTH (TB_DEPTH),
        .TOTAL_BLKS (TB_TOTAL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_0    (we[0]),
        .we_1    (we[1]),
        .we_2    (we[2]),
        .addr_0  (addr[0]),
        .addr_1  (addr[1]),
        .addr_2  (addr[2]),
        .y_0     (y[0]),
        .y_1     (y[1]),
        .y_2     (y[2]),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .ovf     (ovf),
        .seq_err (seq_err),
        .done    (done)
    );

    task automatic model_outputs();
        int g;
        bit found;
        if (mq[0].size() + mq[1].size() + mq[2].size() == 0) begin
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b1;
            g = 0;
            found = 1'b0;
            if (mlock >= 0) begin
                g = mlock;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!found && mq[(mptr + i) % 3].size() > 0) begin
                        g = (mptr + i) % 3;
                        found = 1'b1;
                    end
                end
            end
            exp_ch = g;
            {exp_addr, exp_data} = mq[g][0];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mexp[k] = '0;
            mcnt[k] = 0;
            for (int l = 0; l < 4; l++) mpart[k][l] = '0;
        end
        mptr = 0; mlock = -1;
        movf = 0; mseq = 0; mdone = 0;
        exp_valid = 0; exp_ch = 0; exp_addr = '0; exp_data = '0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state.
    task automatic model_edge();
        int lane;
        if (!mdone && !exp_valid && mcnt[0] == TB_TOTAL &&
            mcnt[1] == TB_TOTAL && mcnt[2] == TB_TOTAL) mdone = 1;
        mlock = -1;
        if (exp_valid) begin
            if (m_ready) begin
                void'(mq[exp_ch].pop_front());
                mptr = (exp_ch + 1) % 3;
            end else begin
                mlock = exp_ch;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (we[k]) begin
                lane = int'(addr[k] % 4);
                if (addr[k] != mexp[k]) mseq = 1;
                mexp[k] = addr[k] + 16'd1;
                if (mcnt[k] < TB_TOTAL) mcnt[k]++;
                mpart[k][lane] = y[k];
                if (lane == 3) begin
                    if (mq[k].size() < TB_DEPTH)
                        mq[k].push_back({addr[k] / 16'd4, mpart[k][3], mpart[k][2],
                                         mpart[k][1], mpart[k][0]});
                    else
                        movf = 1;
                    for (int l = 0; l < 4; l++) mpart[k][l] = '0;
                end
            end
        end
        model_outputs();
    endtask

    // Advance one clock: inputs set by the caller are sampled, then the
    // caller compares at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; addr[k] = '0; y[k] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        m_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL reset_m_ch got=%0d want=0", m_ch); end
        checks++; if (m_addr !== 14'd0) begin errors++; $display("FAIL reset_m_addr got=%0h want=0", m_addr); end
        checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data got=%08h want=0", m_data); end
        checks++; if ({ovf, seq_err, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%03b want=000", {ovf, seq_err, done}); end
        rst_n = 1'b1;
        $display("test_reset: outputs checked while in reset");
    endtask

    task automatic test_single();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            we[0] = 1'b1; addr[0] = 16'(i); y[0] = bytes[i];
            tick();
            if (i < 3) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid byte=%0d got=%0b want=0", i, m_valid); end
            end
        end
        idle_inputs();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", m_valid); end
        checks++; if (m_ch !== 2'd0 || m_addr !== 14'd0) begin errors++; $display("FAIL single_ch_addr got=%0d/%0h want=0/0", m_ch, m_addr); end
        checks++; if (m_data !== 32'h44332211) begin errors++; $display("FAIL single_data got=%08h want=44332211", m_data); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL single_seq_err got=%0b want=0", seq_err); end
        $display("test_single: ch=%0d addr=%0h data=%08h", m_ch, m_addr, m_data);
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_after got=%0b want=0", m_valid); end
    endtask

    task automatic test_all_channels();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                we[k] = 1'b1; addr[k] = 16'(i); y[k] = 8'(16 * (k + 1) + i);
            end
            tick();
        end
        idle_inputs();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_ch !== 2'(b) || m_addr !== 14'd0 || m_data !== exp_data) begin
                errors++;
                $display("FAIL allch_beat%0d got=v%0b ch%0d a%0h d%08h want=v1 ch%0d a0 d%08h", b, m_valid, m_ch, m_addr, m_data, b, exp_data);
            end
            $display("test_all_channels: beat ch=%0d data=%08h", m_ch, m_data);
            tick();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL allch_idle got=%0b want=0", m_valid); end
    endtask

    task automatic test_stall();
        logic [47:0] snap;
        bit          have_snap;
        int          beats;
        int          guard;
        do_reset();
        m_ready = 1'b0;
        have_snap = 1'b0;
        for (int i = 0; i < 80; i++) begin
            we[0] = 1'b1; addr[0] = 16'(i); y[0] = 8'($urandom);
            tick();
            if (m_valid === 1'b1 && !have_snap) begin
                snap = {m_ch, m_addr, m_data}; have_snap = 1'b1;
            end else if (have_snap) begin
                checks++;
                if ({m_valid, m_ch, m_addr, m_data} !== {1'b1, snap}) begin
                    errors++;
                    $display("FAIL stall_stable cyc=%0d got=v%0b %012h want=v1 %012h", i, m_valid, {m_ch, m_addr, m_data}, snap);
                end
            end
        end
        idle_inputs();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL stall_ovf got=%0b want=1", ovf); end
        m_ready = 1'b1;
        beats = 0; guard = 0;
        while (m_valid === 1'b1 && guard < 40) begin
            checks++;
            if (m_ch !== 2'd0 || m_addr !== 14'(beats) || m_data !== exp_data) begin
                errors++;
                $display("FAIL stall_beat%0d got=ch%0d a%0h d%08h want=ch0 a%0h d%08h", beats, m_ch, m_addr, m_data, beats, exp_data);
            end
            beats++; guard++;
            tick();
        end
        checks++; if (beats != 16) begin errors++; $display("FAIL stall_beat_count got=%0d want=16", beats); end
        $display("test_stall: drained %0d beats, ovf=%0b", beats, ovf);
    endtask

    task automatic test_seq_err();
        logic [15:0] seq [3];
        seq[0] = 16'd0; seq[1] = 16'd1; seq[2] = 16'd5;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            we[1] = 1'b1; addr[1] = seq[i]; y[1] = 8'(i + 1);
            tick();
            checks++;
            if (seq_err !== (i == 2)) begin errors++; $display("FAIL seq_err_after%0d got=%0b want=%0b", i, seq_err, i == 2); end
        end
        idle_inputs();
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL seq_no_beat got=%0b want=0", m_valid); end
        $display("test_seq_err: seq_err=%0b m_valid=%0b", seq_err, m_valid);
    endtask

    task automatic test_reset_mid();
        logic [7:0] a_bytes [4];
        a_bytes[0] = 8'hA1; a_bytes[1] = 8'hA2; a_bytes[2] = 8'hA3; a_bytes[3] = 8'hA4;
        do_reset();
        m_ready = 1'b0;
        // Leave a stalled ch0 word, a seq error and two ch2 bytes in flight.
        for (int i = 0; i < 4; i++) begin
            we[0] = 1'b1; addr[0] = 16'(i + 8); y[0] = 8'h5A;
            we[2] = (i < 2); addr[2] = 16'(i); y[2] = 8'h77;
            tick();
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_ch, m_addr, m_data, ovf, seq_err, done} !== '0) begin
            errors++;
            $display("FAIL midreset_zero got=v%0b ch%0d a%0h d%08h f%03b want all 0", m_valid, m_ch, m_addr, m_data, {ovf, seq_err, done});
        end
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            we[2] = 1'b1; addr[2] = 16'(i); y[2] = a_bytes[i];
            tick();
        end
        idle_inputs();
        checks++;
        if (m_valid !== 1'b1 || m_ch !== 2'd2 || m_addr !== 14'd0 || m_data !== 32'hA4A3A2A1) begin
            errors++;
            $display("FAIL midreset_beat got=v%0b ch%0d a%0h d%08h want=v1 ch2 a0 dA4A3A2A1", m_valid, m_ch, m_addr, m_data);
        end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_single got=%0b want=0", m_valid); end
        $display("test_reset_mid: beat after reset checked");
    endtask

    task automatic test_done();
        int beats;
        int guard;
        do_reset();
        beats = 0;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 3; k++) begin
                we[k] = 1'b1; addr[k] = 16'(c); y[k] = 8'($urandom);
            end
            m_ready = c[0];
            if (m_valid === 1'b1 && m_ready) beats++;
            tick();
            checks++;
            if ({m_valid, m_ch, m_addr, m_data, done} !== {exp_valid, 2'(exp_ch), exp_addr, exp_data, mdone}) begin
                errors++;
                $display("FAIL done_write cyc=%0d got=v%0b ch%0d a%0h d%08h dn%0b want=v%0b ch%0d a%0h d%08h dn%0b", c, m_valid, m_ch, m_addr, m_data, done, exp_valid, exp_ch, exp_addr, exp_data, mdone);
            end
        end
        idle_inputs();
        guard = 0;
        while (exp_valid && guard < 60) begin
            m_ready = ~m_ready;
            if (m_valid === 1'b1 && m_ready) beats++;
            guard++;
            tick();
            checks++;
            if ({m_valid, m_ch, m_addr, m_data, done} !== {exp_valid, 2'(exp_ch), exp_addr, exp_data, mdone}) begin
                errors++;
                $display("FAIL done_drain got=v%0b ch%0d a%0h d%08h dn%0b want=v%0b ch%0d a%0h d%08h dn%0b", m_valid, m_ch, m_addr, m_data, done, exp_valid, exp_ch, exp_addr, exp_data, mdone);
            end
        end
        checks++; if (beats != 12) begin errors++; $display("FAIL done_beat_count got=%0d want=12", beats); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got=%0b want=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set got=%0b want=1", done); end
        $display("test_done: %0d beats, done=%0b", beats, done);
    endtask

    task automatic test_random();
        logic [15:0] nxt [3];
        do_reset();
        for (int k = 0; k < 3; k++) nxt[k] = '0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) begin
                we[k] = 1'($urandom);
                if (we[k]) begin
                    addr[k] = ($urandom_range(0, 24) == 0) ? 16'($urandom) : nxt[k];
                    nxt[k]  = addr[k] + 16'd1;
                    y[k]    = 8'($urandom);
                end
            end
            m_ready = (c >= 100 && c < 190) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if ({m_valid, m_ch, m_addr, m_data, ovf, seq_err, done} !==
                {exp_valid, 2'(exp_ch), exp_addr, exp_data, movf, mseq, mdone}) begin
                errors++;
                $display("FAIL random cyc=%0d got=v%0b ch%0d a%0h d%08h f%03b want=v%0b ch%0d a%0h d%08h f%03b", c, m_valid, m_ch, m_addr, m_data, {ovf, seq_err, done}, exp_valid, exp_ch, exp_addr, exp_data, {movf, mseq, mdone});
            end
        end
        idle_inputs();
        $display("test_random: 300 cycles, ovf=%0b seq_err=%0b done=%0b", ovf, seq_err, done);
    endtask

    initial begin
        idle_inputs();
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_all_channels();
        test_stall();
        test_seq_err();
        test_reset_mid();
        test_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
- Receiving end of the conv_pool output write interface: captures the three per-kernel byte write streams (we/addr/y) and packs 4 consecutive pooled bytes per channel into 32-bit words.
- Buffers words in per-channel FIFOs and drains them through one round-robin valid/ready stream toward the result memory/DMA.
- conv_pool cannot be stalled, so the block absorbs bursts, flags drops and address-sequence violations, and signals completion.

Parameters:
ADDR_W, 16, conv_pool output byte address width
NUM_CH, 3, number of kernel channels (fixed structure, 3)
FIFO_DEPTH, 16, words per channel FIFO (power of 2, >=2)
TOTAL_BLKS, 65536, bytes expected per channel for done

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
we_0/we_1/we_2  in  1 each  conv_pool byte write enables
addr_0/addr_1/addr_2  in  ADDR_W each  byte addresses
y_0/y_1/y_2  in  8 each  pooled bytes
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_ch  out  2  channel of current word (0..2)
m_addr  out  ADDR_W-2  word address (addr[ADDR_W-1:2])
m_data  out  32  packed word, lane k = bits [8k+7:8k] = byte at addr lane k
ovf  out  1  sticky: a completed word was dropped (FIFO full)
seq_err  out  1  sticky: write address != expected sequential address
done  out  1  sticky: all channels received TOTAL_BLKS bytes and all FIFOs drained

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, partial-word registers cleared, expected-address counters=0, byte counters=0, grant pointer=ch0, grant lock cleared. Outputs: m_valid=0, m_ch=0, m_addr=0, m_data=0, ovf=0, seq_err=0, done=0. Reset mid-operation discards partial words and buffered data; no beat is produced for them.
- Per-channel packer, on we_k=1:
  - Byte written into lane addr_k[1:0] of the partial word.
  - If addr_k != expected_k, set seq_err; the byte is still packed.
  - expected_k <= addr_k+1, wrapping modulo 2^ADDR_W.
  - Byte counter increments, saturating at TOTAL_BLKS.
- Word completion: a write with lane 3 pushes {addr_k[ADDR_W-1:2], partial word with the new byte} into FIFO k and clears the partial word. Lanes never written in that word read 0.
- Push acceptance: accepted when FIFO k is not full, or when it is full and popped in the same cycle. Otherwise the word is dropped and ovf is set.
- Latency: lane-3 write at edge N -> word visible at FIFO head after edge N; m_valid can assert in cycle N+1 if the channel wins arbitration.
- Arbiter, round-robin over non-empty FIFOs starting from the pointer:
  - On grant, output is {m_ch, m_addr, m_data} from that FIFO head.
  - While m_valid && !m_ready, the grant is locked and all m_* fields are stable.
  - On m_valid && m_ready, FIFO pops and the pointer moves to granted ch+1 (mod 3).
  - One beat per cycle maximum.
- m_valid=0 when all FIFOs are empty; m_ch/m_addr/m_data then hold their last values.
- done:
  - Sets the cycle after every byte counter == TOTAL_BLKS and all FIFOs are empty with no beat pending.
  - Stays set until reset.
  - Writes after done are still packed and output; they do not clear done.
- Simultaneous writes on all three channels in one cycle are fully supported; each channel is independent.

Decomposition:
- Package conv_result_pkg:
  - CH_W=2, NUM_CH=3, PACK=4, LANE_W=8, WORD_W=32
  - typedef word_entry_t = struct {waddr, data}
  - channel index type
- Sub-module result_packer: one per channel. Contains the packer, expected-address check, byte counter and FIFO. It exposes head, empty, pop, ovf_pulse and seq_err_pulse.
- Top level holds the round-robin arbiter, the sticky flags and done.

Test Plan:
- ch0 writes addr 0,1,2,3 with y=11,22,33,44 in consecutive cycles, m_ready=1 -> single beat in the cycle after the addr-3 write: m_ch=0, m_addr=0, m_data=0x44332211; seq_err=0.
- All channels write addr 0..3 in the same cycles, m_ready=1 -> beats in consecutive cycles: m_ch=0, then 1, then 2, each with m_addr=0.
- m_ready=0 while ch0 writes 80 bytes (20 words), then m_ready=1 -> exactly 16 beats, m_addr=0..15 in order; ovf=1; m_* stable throughout the stall.
- ch1 writes addr 0,1,5 -> seq_err=1 after the third write; no beat (lane 1 write only).
- Reset asserted low after 2 bytes of ch2, then released; ch2 writes 0..3 with y=A1..A4 -> all outputs 0 during reset; single beat m_data=0xA4A3A2A1.
- TOTAL_BLKS=16: all channels write addr 0..15 with m_ready toggling every cycle -> 12 beats with correct data; done=1 exactly one cycle after the last beat is accepted.
